// File: rtl/sd_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_scan_pkg
// Description : Shared constants, state encoding and signature helpers for the
//               SD block scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_scan_pkg;

    localparam int SD_BLOCK_BYTES = 512;
    localparam int SD_SIG_BYTES   = 8;
    localparam int SD_ADDR_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT_WAIT = 3'd1,
        ST_REQ       = 3'd2,
        ST_READ      = 3'd3,
        ST_CHECK     = 3'd4,
        ST_FOUND     = 3'd5,
        ST_MISS      = 3'd6,
        ST_ABORT     = 3'd7
    } scan_state_t;

    // Byte 0 of the signature sits in the most significant byte lane.
    function automatic logic [7:0] sig_byte(input logic [63:0] sig, input logic [2:0] idx);
        return 8'(sig >> (8 * (7 - 32'(idx))));
    endfunction

    function automatic logic is_busy(input scan_state_t s);
        return !(s == ST_IDLE || s == ST_FOUND || s == ST_MISS || s == ST_ABORT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_scan_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : sd_scan_watchdog
// Description : Stall counter for the block read; flags expiry on the cycle
//               the count would reach TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_scan_watchdog #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);

    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (run_i) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign expire_o = run_i && !clear_i && (cnt_q == TIMEOUT_CYCLES - 32'd1);

endmodule
`default_nettype wire

// File: rtl/sd_block_scanner.sv
`default_nettype none
// ============================================================================
// Module      : sd_block_scanner
// Description : Walks consecutive SD blocks, streams each into the shared
//               buffer and stops on the first block whose leading 8 bytes
//               equal the signature. Optional watchdog: SD_SCAN_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_block_scanner
    import sd_scan_pkg::*;
#(
    parameter logic [31:0] MAX_BLOCKS     = 32'd65536,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SD_ADDR_W-1:0] start_block,
    input  logic [63:0]          signature,
    input  logic                 init_finish,
    input  logic                 out_valid,
    input  logic [7:0]           sd_dout,
    output logic                 rd_req,
    output logic [SD_ADDR_W-1:0] block_address,
    output logic                 buf_we,
    output logic [8:0]           buf_addr,
    output logic [7:0]           buf_wdata,
    output logic                 busy,
    output logic                 found,
    output logic                 not_found,
    output logic [SD_ADDR_W-1:0] match_block,
    output logic                 timeout
);

    localparam logic [9:0] c_last_byte = 10'(SD_BLOCK_BYTES - 1);
    localparam logic [9:0] c_sig_bytes = 10'(SD_SIG_BYTES);

    scan_state_t          state_q, state_d;
    logic [SD_ADDR_W-1:0] block_address_q;
    logic [SD_ADDR_W-1:0] match_block_q;
    logic [31:0]          scanned_q;
    logic [9:0]           byte_cnt_q;
    logic                 sig_ok_q;
    logic                 rd_req_q;
    logic                 busy_q;
    logic                 found_q;
    logic                 not_found_q;

    logic                 w_take;
    logic                 w_sig_mismatch;
    logic [31:0]          w_scanned_inc;
    logic                 w_wd_expire;

    assign w_take         = (state_q == ST_READ) && out_valid;
    assign w_sig_mismatch = (byte_cnt_q < c_sig_bytes) &&
                            (sd_dout != sig_byte(signature, byte_cnt_q[2:0]));
    assign w_scanned_inc  = scanned_q + 32'd1;

`ifdef SD_SCAN_TIMEOUT_EN
    logic timeout_q;

    sd_scan_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (rd_req_q || out_valid),
        .run_i    (state_q == ST_READ),
        .expire_o (w_wd_expire)
    );
`else
    wire w_unused_cfg = ^TIMEOUT_CYCLES;
    assign w_wd_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_MISS, ST_FOUND: begin
                if (start) state_d = ST_INIT_WAIT;
            end
`ifdef SD_SCAN_TIMEOUT_EN
            ST_ABORT: begin
                if (start) state_d = ST_INIT_WAIT;
            end
`endif
            ST_INIT_WAIT: begin
                if (init_finish) state_d = ST_REQ;
            end
            ST_REQ: state_d = ST_READ;
            ST_READ: begin
                if (w_take && byte_cnt_q == c_last_byte) begin
                    state_d = ST_CHECK;
                end else if (w_wd_expire) begin
                    state_d = ST_ABORT;
                end
            end
            ST_CHECK: begin
                if (sig_ok_q) begin
                    state_d = ST_FOUND;
                end else if (w_scanned_inc == MAX_BLOCKS) begin
                    state_d = ST_MISS;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            block_address_q <= '0;
            match_block_q   <= '0;
            scanned_q       <= '0;
            byte_cnt_q      <= '0;
            sig_ok_q        <= 1'b0;
            rd_req_q        <= 1'b0;
            busy_q          <= 1'b0;
            found_q         <= 1'b0;
            not_found_q     <= 1'b0;
`ifdef SD_SCAN_TIMEOUT_EN
            timeout_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_req_q    <= (state_d == ST_REQ);
            busy_q      <= is_busy(state_d);
            found_q     <= (state_d == ST_FOUND);
            not_found_q <= (state_d == ST_MISS);
`ifdef SD_SCAN_TIMEOUT_EN
            timeout_q   <= (state_d == ST_ABORT);
`endif
            case (state_q)
                ST_IDLE, ST_MISS, ST_ABORT: begin
                    if (start) begin
                        block_address_q <= start_block;
                        scanned_q       <= '0;
                    end
                end
                ST_FOUND: begin
                    if (start) block_address_q <= match_block_q + 32'd1;
                end
                ST_REQ: begin
                    byte_cnt_q <= '0;
                    sig_ok_q   <= 1'b1;
                end
                ST_READ: begin
                    if (w_take) begin
                        byte_cnt_q <= byte_cnt_q + 10'd1;
                        if (w_sig_mismatch) sig_ok_q <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    scanned_q <= w_scanned_inc;
                    if (sig_ok_q) begin
                        match_block_q <= block_address_q;
                    end else begin
                        block_address_q <= block_address_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_req        = rd_req_q;
    assign block_address = block_address_q;
    assign match_block   = match_block_q;
    assign busy          = busy_q;
    assign found         = found_q;
    assign not_found     = not_found_q;
    assign buf_we        = w_take;
    assign buf_addr      = w_take ? byte_cnt_q[8:0] : 9'd0;
    assign buf_wdata     = w_take ? sd_dout : 8'd0;
`ifdef SD_SCAN_TIMEOUT_EN
    assign timeout       = timeout_q;
`else
    assign timeout       = 1'b0;
`endif

endmodule
`default_nettype wire
